// File: rtl/mips_sim_pkg.sv
// Shared types for the simulation write monitor: status encoding and FSM state.
package mips_sim_pkg;

  // Status as seen on the status port; the FSM state uses the same encoding.
  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_PASS    = 2'b01,
    ST_FAIL    = 2'b10,
    ST_TIMEOUT = 2'b11
  } status_e;

  typedef status_e state_t;

endpackage

// File: rtl/wtrace_buf.sv
// Circular trace of the most recent accepted writes (address + data).
module wtrace_buf #(
  parameter int AW     = 64,
  parameter int DW     = 64,
  parameter int TDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [AW-1:0]             wr_adr,
  input  logic [DW-1:0]             wr_data,
  input  logic [$clog2(TDEPTH)-1:0] sel,
  output logic [AW-1:0]             rd_adr,
  output logic [DW-1:0]             rd_data
);
  localparam int TW = $clog2(TDEPTH);

  logic [TDEPTH-1:0][AW-1:0] adr_mem;
  logic [TDEPTH-1:0][DW-1:0] data_mem;
  logic [TDEPTH-1:0]         vld;
  logic [TW-1:0]             wr_ptr;
  logic [TW-1:0]             rd_ptr;

  // Pointer and valid bits; TDEPTH is a power of 2 so the pointer wraps for free.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      vld    <= '0;
    end else if (wr_en) begin
      wr_ptr      <= wr_ptr + TW'(1);
      vld[wr_ptr] <= 1'b1;
    end
  end

  // Storage is not reset; the valid bits mask stale contents.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      adr_mem[wr_ptr]  <= wr_adr;
      data_mem[wr_ptr] <= wr_data;
    end
  end

  // sel = 0 is the newest entry, one slot behind the write pointer.
  always_comb begin
    rd_ptr  = wr_ptr - TW'(1) - sel;
    rd_adr  = vld[rd_ptr] ? adr_mem[rd_ptr]  : '0;
    rd_data = vld[rd_ptr] ? data_mem[rd_ptr] : '0;
  end

endmodule

// File: rtl/sim_write_monitor.sv
// Watches memory writes from a simulated CPU and reports pass/fail/timeout.
module sim_write_monitor
  import mips_sim_pkg::*;
#(
  parameter int DW      = 64,
  parameter int AW      = 64,
  parameter int NSIG    = 2,
  parameter int CW      = 10,
  parameter int TIMEOUT = 192,
  parameter int TDEPTH  = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [1:0]                           memwrite,
  input  logic [AW-1:0]                        dataadr,
  input  logic [DW-1:0]                        writedata,
  input  logic [NSIG*AW-1:0]                   sig_adr,
  input  logic [NSIG*DW-1:0]                   sig_data,
  input  logic [AW-1:0]                        fail_adr,
  input  logic [DW-1:0]                        fail_data,
  input  logic [$clog2(TDEPTH)-1:0]            trace_sel,
  output logic [1:0]                           status,
  output logic                                 done,
  output logic [((NSIG > 1) ? $clog2(NSIG) : 1)-1:0] hit_idx,
  output logic [CW-1:0]                        cycles,
  output logic [CW-1:0]                        wr_count,
  output logic [AW-1:0]                        trace_adr,
  output logic [DW-1:0]                        trace_data
);
  localparam int HW      = (NSIG > 1) ? $clog2(NSIG) : 1;
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  state_t          state_q, state_d;
  logic            acc;
  logic [NSIG-1:0] pmatch;
  logic            fmatch;
  logic [HW-1:0]   pidx;
  logic            to_hit;

  assign acc = (state_q == ST_RUN) && (memwrite != 2'b00);

  generate
    for (genvar i = 0; i < NSIG; i++) begin : g_sig
      assign pmatch[i] = (dataadr == sig_adr[i*AW +: AW]) &&
                         (writedata == sig_data[i*DW +: DW]);
    end
  endgenerate

  assign fmatch = (dataadr == fail_adr) && (writedata == fail_data);
  assign to_hit = (TIMEOUT != 0) && (cycles == CW'(TO_LAST));

  // Lowest matching signature index: scan downward so the smallest hit wins.
  always_comb begin
    pidx = '0;
    for (int i = NSIG - 1; i >= 0; i--)
      if (pmatch[i]) pidx = HW'(i);
  end

  // Next state: fail beats pass, any match beats timeout; non-RUN states hold.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN) begin
      if (acc && fmatch)       state_d = ST_FAIL;
      else if (acc && |pmatch) state_d = ST_PASS;
      else if (to_hit)         state_d = ST_TIMEOUT;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Counters and hit index; cycles counts only edges that stay in RUN, so a
  // timeout freezes it at TIMEOUT-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycles   <= '0;
      wr_count <= '0;
      hit_idx  <= '0;
    end else if (state_q == ST_RUN) begin
      if (state_d == ST_RUN && cycles != '1) cycles <= cycles + CW'(1);
      if (acc && wr_count != '1)             wr_count <= wr_count + CW'(1);
      if (state_d == ST_PASS)                hit_idx <= pidx;
    end
  end

  assign status = state_q;
  assign done   = (state_q != ST_RUN);

  wtrace_buf #(.AW(AW), .DW(DW), .TDEPTH(TDEPTH)) u_trace (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (acc),
    .wr_adr  (dataadr),
    .wr_data (writedata),
    .sel     (trace_sel),
    .rd_adr  (trace_adr),
    .rd_data (trace_data)
  );

endmodule

// File: tb/tb_sim_write_monitor.sv
// Randomized + directed bench for sim_write_monitor against a queue-based model.
module tb_sim_write_monitor;
  localparam int DW = 64, AW = 64, NSIG = 2, CW = 10, TIMEOUT = 192, TDEPTH = 4;
  localparam int HW = 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [1:0]        memwrite = '0;
  logic [AW-1:0]     dataadr = '0;
  logic [DW-1:0]     writedata = '0;
  logic [NSIG*AW-1:0] sig_adr;
  logic [NSIG*DW-1:0] sig_data;
  logic [AW-1:0]     fail_adr;
  logic [DW-1:0]     fail_data;
  logic [1:0]        trace_sel = '0;
  logic [1:0]        status;
  logic              done;
  logic [HW-1:0]     hit_idx;
  logic [CW-1:0]     cycles, wr_count;
  logic [AW-1:0]     trace_adr;
  logic [DW-1:0]     trace_data;

  sim_write_monitor #(.DW(DW), .AW(AW), .NSIG(NSIG), .CW(CW), .TIMEOUT(TIMEOUT), .TDEPTH(TDEPTH)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .sig_adr(sig_adr), .sig_data(sig_data), .fail_adr(fail_adr), .fail_data(fail_data),
    .trace_sel(trace_sel), .status(status), .done(done), .hit_idx(hit_idx), .cycles(cycles),
    .wr_count(wr_count), .trace_adr(trace_adr), .trace_data(trace_data));

  always #10 clk = ~clk;

  // Reference model state: outcome code, counters, newest-first trace queues.
  int            m_status, m_cycles, m_wr, m_hit;
  logic [AW-1:0] q_adr[$];
  logic [DW-1:0] q_data[$];
  int            n_cmp = 0, n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply the spec rules for one rising edge using the inputs present at that edge.
  task automatic model_edge();
    bit acc, f;
    int first;
    if (reset) begin
      m_status = 0; m_cycles = 0; m_wr = 0; m_hit = 0;
      q_adr.delete(); q_data.delete();
    end else if (m_status == 0) begin
      acc   = (memwrite != 0);
      first = -1;
      for (int i = 0; i < NSIG; i++)
        if (acc && first < 0 && dataadr == sig_adr[i*AW +: AW] && writedata == sig_data[i*DW +: DW])
          first = i;
      f = acc && dataadr == fail_adr && writedata == fail_data;
      if (acc) begin
        if (m_wr < 2**CW - 1) m_wr++;
        q_adr.push_front(dataadr); q_data.push_front(writedata);
        if (q_adr.size() > TDEPTH) begin void'(q_adr.pop_back()); void'(q_data.pop_back()); end
      end
      if (f)                                           m_status = 2;
      else if (first >= 0) begin m_status = 1; m_hit = first; end
      else if (TIMEOUT != 0 && m_cycles == TIMEOUT - 1) m_status = 3;
      if (m_status == 0 && m_cycles < 2**CW - 1) m_cycles++;
    end
  endtask

  task automatic check_all();
    chk("status", status, m_status);
    chk("done", done, m_status != 0);
    chk("hit_idx", hit_idx, m_hit);
    chk("cycles", cycles, m_cycles);
    chk("wr_count", wr_count, m_wr);
    for (int s = 0; s < TDEPTH; s++) begin
      trace_sel = s[1:0];
      #1;
      chk("trace_adr", trace_adr, (s < q_adr.size()) ? q_adr[s] : 64'd0);
      chk("trace_data", trace_data, (s < q_data.size()) ? q_data[s] : 64'd0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    memwrite = 2'b00;
    repeat (n) step();
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    memwrite = 2'($urandom_range(1, 3)); dataadr = a; writedata = d;
    step();
    memwrite = 2'b00;
  endtask

  task automatic do_reset();
    reset = 1'b1; memwrite = 2'b00;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic trace_is(input logic [AW-1:0] exp, input logic [1:0] s);
    trace_sel = s; #1;
    chk("trace_sel_adr", trace_adr, exp);
  endtask

  initial begin
    int r;
    sig_adr   = {64'd128, 64'd84};
    sig_data  = {64'd7, 64'd7};
    fail_adr  = 64'hFFF0;
    fail_data = 64'hDEAD;

    // Reset, then sig0 write on the fifth RUN edge.
    do_reset();
    chk("rst_status", status, 0); chk("rst_done", done, 0); chk("rst_wr", wr_count, 0);
    idle(4);
    wr(64'd84, 64'd7);
    chk("s1_status", status, 1); chk("s1_hit", hit_idx, 0); chk("s1_wr", wr_count, 1);

    // sig1 pass, later sig0 write ignored.
    do_reset(); idle(2);
    wr(64'd128, 64'd7);
    chk("s2_status", status, 1); chk("s2_hit", hit_idx, 1);
    wr(64'd84, 64'd7);
    chk("s2_hold_status", status, 1); chk("s2_hold_hit", hit_idx, 1); chk("s2_hold_wr", wr_count, 1);

    // Fail signature equal to sig0: fail wins.
    do_reset(); fail_adr = 64'd84; fail_data = 64'd7; idle(1);
    wr(64'd84, 64'd7);
    chk("s3_status", status, 2);
    fail_adr = 64'hFFF0; fail_data = 64'hDEAD;

    // Timeout after exactly 192 RUN edges, then a match on edge 192 wins.
    do_reset(); idle(191);
    chk("s4_run", status, 0);
    idle(1);
    chk("s4_to", status, 3); chk("s4_cyc", cycles, 191);
    idle(3);
    chk("s4_frozen", cycles, 191);
    do_reset(); idle(191);
    wr(64'd84, 64'd7);
    chk("s4_edge_pass", status, 1);

    // Trace ordering after six writes plus the matching write.
    do_reset();
    for (int a = 1; a <= 6; a++) wr(64'(a), 64'($urandom));
    wr(64'd84, 64'd7);
    trace_is(64'd84, 2'd0); trace_is(64'd6, 2'd1); trace_is(64'd5, 2'd2); trace_is(64'd4, 2'd3);

    // Reset during a matching write mid-RUN, then reset out of PASS.
    do_reset(); idle(3);
    reset = 1'b1; memwrite = 2'b01; dataadr = 64'd84; writedata = 64'd7;
    step();
    reset = 1'b0; memwrite = 2'b00;
    chk("s6_status", status, 0); chk("s6_wr", wr_count, 0);
    wr(64'd84, 64'd7);
    chk("s6_pass", status, 1);
    reset = 1'b1; step(); reset = 1'b0;
    chk("s6_rst_status", status, 0); chk("s6_rst_done", done, 0); chk("s6_rst_hit", hit_idx, 0);
    trace_is(64'd0, 2'd0);

    // Randomized episodes; odd episodes never present signatures so timeout is reachable.
    for (int ep = 0; ep < 8; ep++) begin
      do_reset();
      repeat (230) begin
        reset = ($urandom_range(0, 299) == 0);
        memwrite = ($urandom_range(0, 9) < 4) ? 2'($urandom_range(1, 3)) : 2'b00;
        r = $urandom_range(0, 63);
        if (ep % 2 == 0 && r < 2)       begin dataadr = 64'd84;  writedata = 64'd7; end
        else if (ep % 2 == 0 && r < 4)  begin dataadr = 64'd128; writedata = 64'd7; end
        else if (ep % 2 == 0 && r < 5)  begin dataadr = fail_adr; writedata = fail_data; end
        else if (r < 12) begin dataadr = 64'd84; writedata = 64'($urandom_range(8, 15)); end
        else begin dataadr = 64'($urandom_range(0, 255)); writedata = 64'($urandom); end
        step();
      end
      reset = 1'b0; memwrite = 2'b00;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/sim_write_monitor.md
SIM_WRITE_MONITOR -- requirements
Module: sim_write_monitor

Interface
REQ-001 SHALL have parameter DW, default 64, meaning data width.
REQ-002 SHALL have parameter AW, default 64, meaning address width.
REQ-003 SHALL have parameter NSIG, default 2, meaning number of pass signatures.
REQ-004 SHALL have parameter CW, default 10, meaning cycle and write counter width.
REQ-005 SHALL have parameter TIMEOUT, default 192, meaning cycle limit; 0 disables the limit.
REQ-006 SHALL have parameter TDEPTH, default 4, meaning trace depth; must be a power of 2 and at least 2.
REQ-007 SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-008 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-009 SHALL have port memwrite, input, 2 bits, write strobe; any nonzero value is a write.
REQ-010 SHALL have port dataadr, input, AW bits, write address.
REQ-011 SHALL have port writedata, input, DW bits, write data.
REQ-012 SHALL have port sig_adr, input, NSIG*AW bits, pass addresses, entry i at [i*AW +: AW]; quasi-static.
REQ-013 SHALL have port sig_data, input, NSIG*DW bits, pass data, same packing as sig_adr.
REQ-014 SHALL have port fail_adr, input, AW bits, fail signature address.
REQ-015 SHALL have port fail_data, input, DW bits, fail signature data.
REQ-016 SHALL have port trace_sel, input, $clog2(TDEPTH) bits, trace entry select; 0 is the newest entry.
REQ-017 SHALL have port status, output, 2 bits: 00 RUN, 01 PASS, 10 FAIL, 11 TIMEOUT.
REQ-018 SHALL have port done, output, 1 bit, high whenever status is not RUN.
REQ-019 SHALL have port hit_idx, output, max(1,$clog2(NSIG)) bits, index of the pass signature that matched.
REQ-020 SHALL have ports cycles and wr_count, output, CW bits each: RUN cycle count and accepted write count.
REQ-021 SHALL have ports trace_adr and trace_data, output, AW and DW bits, the selected trace entry.

Function
REQ-022 SHALL implement a four-state FSM (RUN, PASS, FAIL, TIMEOUT); PASS, FAIL and TIMEOUT are terminal until reset.
REQ-023 SHALL define a write as accepted when state is RUN and memwrite is nonzero at the clk rising edge.
REQ-024 SHALL define pass match i as an accepted write where dataadr equals sig_adr[i] and writedata equals sig_data[i].
REQ-025 SHALL go to PASS on any pass match, loading hit_idx with the lowest matching i.
REQ-026 SHALL go to FAIL when an accepted write matches fail_adr/fail_data; FAIL wins if it occurs together with a pass match.
REQ-027 SHALL update status one cycle after the edge that sampled the matching write, with no extra latency.
REQ-028 SHALL increment cycles on every RUN cycle, saturating at all-ones.
REQ-029 SHALL go to TIMEOUT when TIMEOUT is nonzero, cycles equals TIMEOUT-1 and no match occurs on that edge; a match on that edge wins.
REQ-030 SHALL increment wr_count on each accepted write, including the matching write, saturating at all-ones.
REQ-031 SHALL freeze cycles, wr_count and hit_idx after leaving RUN.
REQ-032 SHALL hold a circular trace of the last TDEPTH accepted writes (address and data); the write pointer wraps modulo TDEPTH.
REQ-033 SHALL drive trace_adr/trace_data combinationally from the entry at (wr_ptr-1-trace_sel) mod TDEPTH; entries never written read as zero.
REQ-034 SHALL stop capturing into the trace after leaving RUN, so the matching write is the newest entry.

Reset
REQ-035 SHALL on reset force state RUN and clear cycles, wr_count, hit_idx, the trace pointer and all trace valid bits; status=00, done=0, trace outputs=0.
REQ-036 SHALL give reset priority over every event; reset asserted in the same cycle as a matching write clears the block and the write is not counted.

Structure
REQ-037 SHALL place the status encoding enum and the state typedef in the shared package mips_sim_pkg.
REQ-038 SHALL implement the trace as one sub-module, wtrace_buf, holding storage, pointer and valid bits.

Verification
REQ-039 SHALL cover: reset, then write adr 84 data 7 (sig0) on cycle 5 -> status=01, hit_idx=0, wr_count=1 one cycle later.
REQ-040 SHALL cover: write adr 128 data 7 (sig1) -> PASS with hit_idx=1; a later sig0 write leaves status, hit_idx and wr_count unchanged.
REQ-041 SHALL cover: fail_adr=fail_data=sig0 values, then write that pair -> status=10.
REQ-042 SHALL cover: no matching write -> status=11 exactly after 192 RUN cycles, cycles=191 frozen; a match on the 192nd edge -> PASS.
REQ-043 SHALL cover: six writes (adr 1..6) then sig0 -> trace_sel 0..3 return adr 84, 6, 5, 4.
REQ-044 SHALL cover: reset asserted mid-RUN and in PASS -> all outputs return to reset values next cycle.
